// File: rtl/mem_access_guard.sv
// mem_access_guard
// MEM-stage load/store checker for the pipelined MIPS core. A small table of
// programmable address windows (base/mask/attr) decides whether each access is
// legal. Illegal accesses gate the memory write enable through access_ok. They
// are also latched into an exception record for CP0 and counted in a
// saturating fault counter.

module mem_access_guard #(
   parameter int ADDR_W      = 32,
   parameter int NUM_REGIONS = 4,
   parameter int CNT_W       = 8,
   parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [1:0]        cfg_sel,
   input  logic [ADDR_W-1:0] cfg_wdata,
   output logic [ADDR_W-1:0] cfg_rdata,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   output logic              access_ok,
   output logic              exc_valid,
   output logic [4:0]        exc_code,
   output logic [1:0]        fault_kind,
   output logic [ADDR_W-1:0] bad_vaddr,
   input  logic              exc_ack,
   output logic [CNT_W-1:0]  fault_cnt
);

   // Reason a memory op was rejected; the encoding is what CP0 reads.
   typedef enum logic [1:0] {
      FK_NONE     = 2'd0,
      FK_MISALIGN = 2'd1,
      FK_NOREGION = 2'd2,
      FK_PERM     = 2'd3
   } faultKind_e;

   // Attribute bit positions inside each region's attr field.
   localparam int ATTR_EN  = 0;
   localparam int ATTR_RD  = 1;
   localparam int ATTR_WR  = 2;
   localparam int ATTR_SUB = 3;

   // Power-on window layout: boot RAM, data RAM and the word-only timer block.
   localparam logic [31:0] R0_BASE = 32'h0000_0000;
   localparam logic [31:0] R0_MASK = 32'hFFFF_E000;
   localparam logic [3:0]  R0_ATTR = 4'hF;
   localparam logic [31:0] R1_BASE = 32'h0000_2000;
   localparam logic [31:0] R1_MASK = 32'hFFFF_F000;
   localparam logic [3:0]  R1_ATTR = 4'hF;
   localparam logic [31:0] R2_BASE = 32'h0000_7F00;
   localparam logic [31:0] R2_MASK = 32'hFFFF_FFE8;
   localparam logic [3:0]  R2_ATTR = 4'h7;

   localparam logic [4:0] CODE_ADEL = 5'd4;
   localparam logic [4:0] CODE_ADES = 5'd5;

   // Region table
   logic [ADDR_W-1:0] regionBase_q [NUM_REGIONS];
   logic [ADDR_W-1:0] regionMask_q [NUM_REGIONS];
   logic [3:0]        regionAttr_q [NUM_REGIONS];

   // Exception record and fault counter
   logic              excValid_q, excValid_d;
   logic [4:0]        excCode_q, excCode_d;
   faultKind_e        faultKind_q, faultKind_d;
   logic [ADDR_W-1:0] badVaddr_q, badVaddr_d;
   logic [CNT_W-1:0]  faultCnt_q, faultCnt_d;

   // Request decode
   logic       cfgIdxValid;
   logic       memOp;
   logic       isStore;
   logic       isWord;
   logic       isHalf;
   logic       misaligned;
   logic       hitFound;
   logic [3:0] hitAttr;
   logic       permBad;
   faultKind_e faultNow;
   logic       fault;

   // An index beyond the table silently drops writes and reads back as zero.
   assign cfgIdxValid = (int'(cfg_idx) < NUM_REGIONS);

   // A request carrying both load and store is handled as a store.
   assign memOp   = req_valid & (req_load | req_store);
   assign isStore = req_store;
   assign isWord  = req_size[1];
   assign isHalf  = (req_size == 2'd1);

   assign misaligned = (isWord && (req_addr[1:0] != 2'b00)) ||
                       (isHalf && req_addr[0]);

   // Scan from the top index down so the lowest-index hit is the one left standing.
   always_comb begin
      hitFound = 1'b0;
      hitAttr  = 4'h0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if (regionAttr_q[r][ATTR_EN] &&
             ((req_addr & regionMask_q[r]) == (regionBase_q[r] & regionMask_q[r]))) begin
            hitFound = 1'b1;
            hitAttr  = regionAttr_q[r];
         end
      end
   end

   assign permBad = (isStore ? !hitAttr[ATTR_WR] : !hitAttr[ATTR_RD]) ||
                    (!isWord && !hitAttr[ATTR_SUB]);

   // Classify the access; alignment beats region lookup, which beats permissions.
   always_comb begin
      faultNow = FK_NONE;
      if (memOp) begin
         if (misaligned) begin
            faultNow = FK_MISALIGN;
         end else if (!hitFound) begin
            faultNow = FK_NOREGION;
         end else if (permBad) begin
            faultNow = FK_PERM;
         end
      end
   end

   assign fault     = (faultNow != FK_NONE);
   assign access_ok = !memOp || !fault;

   // Combinational readback of the selected table field.
   always_comb begin
      cfg_rdata = '0;
      if (cfgIdxValid) begin
         case (cfg_sel)
            2'd0:    cfg_rdata = regionBase_q[cfg_idx];
            2'd1:    cfg_rdata = regionMask_q[cfg_idx];
            2'd2:    cfg_rdata = ADDR_W'(regionAttr_q[cfg_idx]);
            default: cfg_rdata = '0;
         endcase
      end
   end

   // Table storage: reset layout, then software writes land on the clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGIONS; r++) begin
            if (r == 0) begin
               regionBase_q[r] <= ADDR_W'(R0_BASE);
               regionMask_q[r] <= ADDR_W'(R0_MASK);
               regionAttr_q[r] <= R0_ATTR;
            end else if (r == 1) begin
               regionBase_q[r] <= ADDR_W'(R1_BASE);
               regionMask_q[r] <= ADDR_W'(R1_MASK);
               regionAttr_q[r] <= R1_ATTR;
            end else if (r == 2) begin
               regionBase_q[r] <= ADDR_W'(R2_BASE);
               regionMask_q[r] <= ADDR_W'(R2_MASK);
               regionAttr_q[r] <= R2_ATTR;
            end else begin
               regionBase_q[r] <= '0;
               regionMask_q[r] <= '0;
               regionAttr_q[r] <= 4'h0;
            end
         end
      end else if (cfg_we && cfgIdxValid) begin
         case (cfg_sel)
            2'd0:    regionBase_q[cfg_idx] <= cfg_wdata;
            2'd1:    regionMask_q[cfg_idx] <= cfg_wdata;
            2'd2:    regionAttr_q[cfg_idx] <= cfg_wdata[3:0];
            default: ;
         endcase
      end
   end

   // Next-state for the exception record and the saturating counter.
   always_comb begin
      excValid_d  = excValid_q;
      excCode_d   = excCode_q;
      faultKind_d = faultKind_q;
      badVaddr_d  = badVaddr_q;
      faultCnt_d  = faultCnt_q;
      if (fault && (!excValid_q || exc_ack)) begin
         excValid_d  = 1'b1;
         excCode_d   = isStore ? CODE_ADES : CODE_ADEL;
         faultKind_d = faultNow;
         badVaddr_d  = req_addr;
      end else if (exc_ack) begin
         excValid_d  = 1'b0;
         excCode_d   = 5'd0;
         faultKind_d = FK_NONE;
      end
      if (fault && (faultCnt_q != {CNT_W{1'b1}})) begin
         faultCnt_d = faultCnt_q + CNT_W'(1);
      end
   end

   // Record and counter registers; reset wipes a held record immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         excValid_q  <= 1'b0;
         excCode_q   <= 5'd0;
         faultKind_q <= FK_NONE;
         badVaddr_q  <= '0;
         faultCnt_q  <= '0;
      end else begin
         excValid_q  <= excValid_d;
         excCode_q   <= excCode_d;
         faultKind_q <= faultKind_d;
         badVaddr_q  <= badVaddr_d;
         faultCnt_q  <= faultCnt_d;
      end
   end

   assign exc_valid  = excValid_q;
   assign exc_code   = excCode_q;
   assign fault_kind = faultKind_q;
   assign bad_vaddr  = badVaddr_q;
   assign fault_cnt  = faultCnt_q;

endmodule

// File: tb/tb_mem_access_guard.sv
// Testbench for mem_access_guard: directed scenarios plus a randomized run,
// all checked against a rule-level model of the region table and CP0 record.

module tb_mem_access_guard;

   logic        clk;
   logic        reset_n;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [1:0]  cfg_sel;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_load;
   logic        req_store;
   logic [1:0]  req_size;
   logic        access_ok;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [1:0]  fault_kind;
   logic [31:0] bad_vaddr;
   logic        exc_ack;
   logic [7:0]  fault_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] mBase [4];
   logic [31:0] mMask [4];
   logic [3:0]  mAttr [4];
   logic        expValid;
   logic [4:0]  expCode;
   logic [1:0]  expKind;
   logic [31:0] expVaddr;
   int          expCnt;

   mem_access_guard dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_sel    (cfg_sel),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_load   (req_load),
      .req_store  (req_store),
      .req_size   (req_size),
      .access_ok  (access_ok),
      .exc_valid  (exc_valid),
      .exc_code   (exc_code),
      .fault_kind (fault_kind),
      .bad_vaddr  (bad_vaddr),
      .exc_ack    (exc_ack),
      .fault_cnt  (fault_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: which fault (0 = none) an access produces against the model table.
   function automatic int modelKind(logic v, logic ld, logic st, logic [1:0] sz, logic [31:0] a);
      int bytes;
      int hit;
      if (!(v && (ld || st))) return 0;
      bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if ((a % bytes) != 0) return 1;
      hit = -1;
      for (int r = 0; r < 4; r++) begin
         if (hit < 0 && mAttr[r][0] && ((a & mMask[r]) == (mBase[r] & mMask[r]))) hit = r;
      end
      if (hit < 0) return 2;
      if (st && !mAttr[hit][2]) return 3;
      if (!st && !mAttr[hit][1]) return 3;
      if (bytes < 4 && !mAttr[hit][3]) return 3;
      return 0;
   endfunction

   function automatic logic [31:0] modelRead(logic [1:0] idx, logic [1:0] sel);
      case (sel)
         2'd0:    return mBase[idx];
         2'd1:    return mMask[idx];
         2'd2:    return {28'h0, mAttr[idx]};
         default: return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      mBase[0] = 32'h0000_0000; mMask[0] = 32'hFFFF_E000; mAttr[0] = 4'hF;
      mBase[1] = 32'h0000_2000; mMask[1] = 32'hFFFF_F000; mAttr[1] = 4'hF;
      mBase[2] = 32'h0000_7F00; mMask[2] = 32'hFFFF_FFE8; mAttr[2] = 4'h7;
      mBase[3] = 32'h0;         mMask[3] = 32'h0;         mAttr[3] = 4'h0;
      expValid = 1'b0; expCode = 5'd0; expKind = 2'd0; expVaddr = 32'h0; expCnt = 0;
   endtask

   task automatic setReq(logic v, logic ld, logic st, logic [1:0] sz, logic [31:0] a, logic ack);
      req_valid = v; req_load = ld; req_store = st; req_size = sz; req_addr = a; exc_ack = ack;
   endtask

   task automatic setCfg(logic we, logic [1:0] idx, logic [1:0] sel, logic [31:0] wd);
      cfg_we = we; cfg_idx = idx; cfg_sel = sel; cfg_wdata = wd;
   endtask

   // Advance one rising edge, updating the model from the inputs present at that edge.
   task automatic applyStimulus();
      int          k;
      logic        st, ack, we;
      logic [1:0]  idx, sel;
      logic [31:0] a, wd;
      k   = modelKind(req_valid, req_load, req_store, req_size, req_addr);
      st  = req_store; ack = exc_ack; a = req_addr;
      we  = cfg_we; idx = cfg_idx; sel = cfg_sel; wd = cfg_wdata;
      @(posedge clk);
      if (k != 0) begin
         if (expCnt < 255) expCnt++;
         if (!expValid || ack) begin
            expValid = 1'b1; expCode = st ? 5'd5 : 5'd4; expKind = 2'(k); expVaddr = a;
         end
      end else if (ack) begin
         expValid = 1'b0; expCode = 5'd0; expKind = 2'd0;
      end
      if (we) begin
         case (sel)
            2'd0:    mBase[idx] = wd;
            2'd1:    mMask[idx] = wd;
            2'd2:    mAttr[idx] = wd[3:0];
            default: ;
         endcase
      end
      #1;
      setReq(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b0);
      setCfg(1'b0, 2'd0, 2'd0, 32'h0);
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (exc_valid !== 1'b0 || exc_code !== 5'd0 || fault_kind !== 2'd0 ||
          bad_vaddr !== 32'h0 || fault_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_record: got v=%0b code=%0d kind=%0d vaddr=%h cnt=%0d, expected all zero",
                  exc_valid, exc_code, fault_kind, bad_vaddr, fault_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         for (int s = 0; s < 4; s++) begin
            setCfg(1'b0, 2'(i), 2'(s), 32'h0);
            #1;
            checks++;
            if (cfg_rdata !== modelRead(2'(i), 2'(s))) begin
               errors++;
               $display("[TB] FAIL reset_table idx=%0d sel=%0d: got %h expected %h",
                        i, s, cfg_rdata, modelRead(2'(i), 2'(s)));
            end
         end
      end
      setCfg(1'b0, 2'd0, 2'd0, 32'h0);
   endtask

   task automatic test_basic();
      setReq(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_1FFC, 1'b0);
      #2;
      checks++;
      if (access_ok !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_load_ok: got %0b expected 1", access_ok);
      end
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b0 || fault_cnt !== 8'd0) begin
         errors++; $display("[TB] FAIL basic_no_exc: got v=%0b cnt=%0d expected v=0 cnt=0", exc_valid, fault_cnt);
      end
      setReq(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_0002, 1'b0);
      #2;
      checks++;
      if (access_ok !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_store_mis_ok: got %0b expected 0", access_ok);
      end
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b1 || exc_code !== 5'd5 || fault_kind !== 2'd1 ||
          bad_vaddr !== 32'h0000_0002 || fault_cnt !== 8'd1) begin
         errors++;
         $display("[TB] FAIL basic_store_mis_rec: got v=%0b code=%0d kind=%0d vaddr=%h cnt=%0d expected 1/5/1/00000002/1",
                  exc_valid, exc_code, fault_kind, bad_vaddr, fault_cnt);
      end
      setReq(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b1);
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b0 || exc_code !== 5'd0 || fault_kind !== 2'd0 || bad_vaddr !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL basic_ack_clear: got v=%0b code=%0d kind=%0d vaddr=%h expected 0/0/0/00000002",
                  exc_valid, exc_code, fault_kind, bad_vaddr);
      end
   endtask

   task automatic test_regions();
      logic [31:0] addrs [3];
      logic [1:0]  sizes [3];
      logic [1:0]  kinds [3];
      addrs[0] = 32'h0000_7F01; sizes[0] = 2'd0; kinds[0] = 2'd3;
      addrs[1] = 32'h0000_7F14; sizes[1] = 2'd2; kinds[1] = 2'd0;
      addrs[2] = 32'h0000_3000; sizes[2] = 2'd2; kinds[2] = 2'd2;
      for (int i = 0; i < 3; i++) begin
         setReq(1'b1, 1'b1, 1'b0, sizes[i], addrs[i], 1'b1);
         #2;
         checks++;
         if (access_ok !== (kinds[i] == 2'd0)) begin
            errors++; $display("[TB] FAIL region_ok addr=%h: got %0b expected %0b", addrs[i], access_ok, kinds[i] == 2'd0);
         end
         applyStimulus();
         checks++;
         if (fault_kind !== kinds[i] || exc_code !== ((kinds[i] == 2'd0) ? 5'd0 : 5'd4) ||
             fault_cnt !== 8'(expCnt)) begin
            errors++;
            $display("[TB] FAIL region_rec addr=%h: got kind=%0d code=%0d cnt=%0d expected kind=%0d cnt=%0d",
                     addrs[i], fault_kind, exc_code, fault_cnt, kinds[i], expCnt);
         end
      end
      setReq(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b1);
      applyStimulus();
   endtask

   task automatic test_hold();
      int cnt0;
      cnt0 = expCnt;
      setReq(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_0002, 1'b0);
      applyStimulus();
      setReq(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_4000, 1'b0);
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b1 || bad_vaddr !== 32'h0000_0002 || fault_kind !== 2'd1 ||
          exc_code !== 5'd5 || fault_cnt !== 8'(cnt0 + 2)) begin
         errors++;
         $display("[TB] FAIL hold_unchanged: got v=%0b vaddr=%h kind=%0d code=%0d cnt=%0d expected 1/00000002/1/5/%0d",
                  exc_valid, bad_vaddr, fault_kind, exc_code, fault_cnt, cnt0 + 2);
      end
      setReq(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 1'b1);
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b1 || bad_vaddr !== 32'h0000_5000 || fault_kind !== 2'd2 ||
          exc_code !== 5'd4 || fault_cnt !== 8'(cnt0 + 3)) begin
         errors++;
         $display("[TB] FAIL hold_ack_replace: got v=%0b vaddr=%h kind=%0d code=%0d cnt=%0d expected 1/00005000/2/4/%0d",
                  exc_valid, bad_vaddr, fault_kind, exc_code, fault_cnt, cnt0 + 3);
      end
   endtask

   task automatic test_config();
      setReq(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b1);
      setCfg(1'b1, 2'd3, 2'd0, 32'h1000_0000);
      applyStimulus();
      setCfg(1'b1, 2'd3, 2'd1, 32'hFFFF_0000);
      applyStimulus();
      setCfg(1'b1, 2'd3, 2'd3, 32'hDEAD_BEEF);
      #2;
      checks++;
      if (cfg_rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL cfg_reserved_read: got %h expected 00000000", cfg_rdata);
      end
      applyStimulus();
      setCfg(1'b1, 2'd3, 2'd2, 32'h0000_0003);
      setReq(1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0010, 1'b0);
      #2;
      checks++;
      if (access_ok !== 1'b0) begin
         errors++; $display("[TB] FAIL cfg_old_table: got %0b expected 0", access_ok);
      end
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b1 || fault_kind !== 2'd2 || bad_vaddr !== 32'h1000_0010) begin
         errors++;
         $display("[TB] FAIL cfg_old_table_rec: got v=%0b kind=%0d vaddr=%h expected 1/2/10000010",
                  exc_valid, fault_kind, bad_vaddr);
      end
      setCfg(1'b0, 2'd3, 2'd2, 32'h0);
      setReq(1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0010, 1'b1);
      #2;
      checks++;
      if (access_ok !== 1'b1 || cfg_rdata !== 32'h3) begin
         errors++; $display("[TB] FAIL cfg_new_table: got ok=%0b attr=%h expected ok=1 attr=00000003", access_ok, cfg_rdata);
      end
      applyStimulus();
      setReq(1'b1, 1'b0, 1'b1, 2'd2, 32'h1000_0010, 1'b1);
      applyStimulus();
      checks++;
      if (exc_valid !== 1'b1 || fault_kind !== 2'd3 || exc_code !== 5'd5 || fault_cnt !== 8'(expCnt)) begin
         errors++;
         $display("[TB] FAIL cfg_store_ro: got v=%0b kind=%0d code=%0d cnt=%0d expected 1/3/5/%0d",
                  exc_valid, fault_kind, exc_code, fault_cnt, expCnt);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         setReq(1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_0002, 1'b0);
         applyStimulus();
         checks++;
         if (fault_cnt !== 8'(expCnt)) begin
            errors++; $display("[TB] FAIL saturate_step %0d: got %0d expected %0d", i, fault_cnt, expCnt);
         end
      end
      checks++;
      if (fault_cnt !== 8'd255) begin
         errors++; $display("[TB] FAIL saturate_final: got %0d expected 255", fault_cnt);
      end
   endtask

   task automatic test_reset_mid_hold();
      checks++;
      if (exc_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL midreset_pre_hold: got %0b expected 1", exc_valid);
      end
      setCfg(1'b0, 2'd3, 2'd0, 32'h0);
      #1;
      reset_n = 1'b0;
      #1;
      modelReset();
      checks++;
      if (exc_valid !== 1'b0 || exc_code !== 5'd0 || fault_kind !== 2'd0 ||
          bad_vaddr !== 32'h0 || fault_cnt !== 8'd0 || cfg_rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_async: got v=%0b code=%0d kind=%0d vaddr=%h cnt=%0d base3=%h expected all zero",
                  exc_valid, exc_code, fault_kind, bad_vaddr, fault_cnt, cfg_rdata);
      end
      #4;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [31:0] bases [5];
      int          k;
      bases[0] = 32'h0000_0000; bases[1] = 32'h0000_2000; bases[2] = 32'h0000_7F00;
      bases[3] = 32'h0000_3000; bases[4] = 32'h1000_0000;
      for (int i = 0; i < 400; i++) begin
         setReq(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
                bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0));
         setCfg(($urandom_range(0, 7) == 0), 2'($urandom_range(2, 3)), 2'($urandom),
                ($urandom_range(0, 1) == 0) ? bases[$urandom_range(0, 4)] : $urandom);
         #2;
         k = modelKind(req_valid, req_load, req_store, req_size, req_addr);
         checks++;
         if (access_ok !== (k == 0) || cfg_rdata !== modelRead(cfg_idx, cfg_sel)) begin
            errors++;
            $display("[TB] FAIL rand_comb %0d: got ok=%0b rdata=%h expected ok=%0b rdata=%h",
                     i, access_ok, cfg_rdata, k == 0, modelRead(cfg_idx, cfg_sel));
         end
         applyStimulus();
         checks++;
         if (exc_valid !== expValid || exc_code !== expCode || fault_kind !== expKind ||
             bad_vaddr !== expVaddr || fault_cnt !== 8'(expCnt)) begin
            errors++;
            $display("[TB] FAIL rand_rec %0d: got v=%0b code=%0d kind=%0d vaddr=%h cnt=%0d expected v=%0b code=%0d kind=%0d vaddr=%h cnt=%0d",
                     i, exc_valid, exc_code, fault_kind, bad_vaddr, fault_cnt,
                     expValid, expCode, expKind, expVaddr, expCnt);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      setReq(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 1'b0);
      setCfg(1'b0, 2'd0, 2'd0, 32'h0);
      modelReset();
      #12;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_regions();
      test_hold();
      test_config();
      test_saturate();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_guard.md
# mem_access_guard

Parametrised MEM-stage access checker for the pipelined MIPS core. It replaces fixed address-range and alignment checks with a table of NUM_REGIONS programmable windows, each with its own permissions. Illegal loads and stores are latched into a held exception record (code, BadVAddr, fault kind) for CP0, and a saturating fault counter runs alongside. It sits between the MEM-stage address path and the data-memory / bridge write enable.

## Interface
- ADDR_W, 32, address width
- NUM_REGIONS, 4, number of programmable windows (1..16)
- CNT_W, 8, fault counter width
- IDX_W, $clog2(NUM_REGIONS) (min 1), region index width

- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  config write strobe
- cfg_idx  in  IDX_W  region selected for write/readback
- cfg_sel  in  2  field: 0 base, 1 mask, 2 attr, 3 reserved (writes ignored, reads 0)
- cfg_wdata  in  ADDR_W  config write data
- cfg_rdata  out  ADDR_W  combinational readback of the selected field
- req_valid  in  1  MEM stage holds a valid instruction
- req_addr  in  ADDR_W  effective address
- req_load  in  1  instruction is a load
- req_store  in  1  instruction is a store
- req_size  in  2  0 byte, 1 half, 2 word (3 treated as word)
- access_ok  out  1  combinational; access permitted or not a memory op
- exc_valid  out  1  exception record held
- exc_code  out  5  4 = AdEL, 5 = AdES, 0 when not held
- fault_kind  out  2  1 misaligned, 2 no region, 3 permission
- bad_vaddr  out  ADDR_W  faulting address
- exc_ack  in  1  CP0 consumed the record
- fault_cnt  out  CNT_W  saturating count of all faults

## Operation
- Each region has base, mask, and attr. Attr bits: [0] enable, [1] read, [2] write, [3] sub-word allowed.
- A region hits when enable is set and (req_addr & mask) == (base & mask). The lowest-index hit wins; later hits are ignored.
- Reset table:
  - region 0: base 0x0000_0000, mask 0xFFFF_E000, attr 0xF
  - region 1: base 0x0000_2000, mask 0xFFFF_F000, attr 0xF
  - region 2: base 0x0000_7F00, mask 0xFFFF_FFE8, attr 0x7 (timer words, word-only)
  - all other regions: zero
- A memory op is req_valid & (req_load | req_store). If both are set, treat it as a store.
- Fault evaluation for a memory op, first match wins:
  1. misaligned: word with addr[1:0] != 0, or half with addr[0] != 0
  2. no region hit
  3. permission: load without read, store without write, or size < word without sub-word
- access_ok = !memop | !fault. This replaces the memory write enable gate.
- Capture rule: on fault, when exc_valid == 0 or exc_ack == 1, the next edge loads:
  - exc_valid = 1
  - exc_code = 5 for a store, else 4
  - fault_kind
  - bad_vaddr = req_addr
- Hold rule: a fault while the record is held and not acked is not captured. It is still counted.
- exc_ack with no new fault clears exc_valid, exc_code, and fault_kind. bad_vaddr keeps its last value.
- fault_cnt increments by 1 per faulting cycle and saturates at all-ones, with no wrap.
- Config writes take effect at the edge. A request in the same cycle is checked against the pre-write table.
- Writes to an index >= NUM_REGIONS are ignored; reads of such an index return 0.

## Timing
- access_ok and cfg_rdata are pure combinational, with zero latency.
- Exception record and counter are registered: a fault in cycle N gives exc_valid = 1 in cycle N+1.
- Reset: exc_valid 0, exc_code 0, fault_kind 0, bad_vaddr 0, fault_cnt 0, table at reset values.
- Reset asserted mid-hold clears the record immediately, asynchronously.
- Simultaneous exc_ack and new fault: the new record replaces the old, exc_valid stays 1, and the count increments.
- Simultaneous cfg_we and fault: both take effect at the same edge, and the fault uses the old table.

## Test plan
- Reset, then word load at 0x0000_1FFC → access_ok 1, exc_valid stays 0, fault_cnt 0.
- Word store at 0x0000_0002 → access_ok 0. Next cycle: exc_valid 1, exc_code 5, fault_kind 1, bad_vaddr 0x0000_0002, fault_cnt 1.
- Byte load at 0x0000_7F01 → fault_kind 3 (region 2 has no sub-word), exc_code 4. Word load at 0x0000_7F14 → ok. Load at 0x0000_3000 → fault_kind 2.
- Hold a fault at 0x0000_0002, then a second fault at 0x0000_4000 without ack → record unchanged, fault_cnt 2. Then ack together with a fault at 0x0000_5000 → bad_vaddr 0x0000_5000, exc_valid 1, fault_cnt 3.
- Program region 3: base 0x1000_0000, mask 0xFFFF_0000, attr 0x3 (read-only). Same cycle, load at 0x1000_0010 → fault (old table). Next cycle, same load → ok. Store there → fault_kind 3, exc_code 5.
- Force 300 consecutive faults with CNT_W = 8 → fault_cnt saturates at 255. Pulse reset_n low mid-hold → all outputs return to reset values before the next clock edge.
